// File: rtl/sa_bist_pkg.sv
// Shared types and helpers for the systolic-array BIST driver.
// FSM encoding, stimulus mode codes and lane replication.
package sa_bist_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_BIAS,
      S_STREAM,
      S_WAIT,
      S_DONE
   } state_t;

   localparam logic [1:0] MODE_CONST    = 2'd0;
   localparam logic [1:0] MODE_RAMP_ACT = 2'd1;
   localparam logic [1:0] MODE_RAMP_WGT = 2'd2;
   localparam logic [1:0] MODE_RSVD     = 2'd3;

   localparam int REP_MAX = 1024;
   localparam int REP_W   = 64;

   // Copies the low w bits of v into n adjacent lanes; callers cast to size.
   function automatic logic [REP_MAX-1:0] rep_lanes(
      input logic [REP_W-1:0] v,
      input int               w,
      input int               n
   );
      logic [REP_MAX-1:0] r;
      r = '0;
      for (int i = 0; i < REP_MAX; i++) begin
         if (i < w * n) r[i] = v[i % w];
      end
      return r;
   endfunction

endpackage

// File: rtl/sa_bist_expected_acc.sv
// Expected-value MAC: loads the tile bias, then adds N*act*wgt per step.
// All arithmetic wraps modulo 2^ACC_WIDTH.
module sa_bist_expected_acc #(
   parameter int ARRAY_N    = 4,
   parameter int ACT_WIDTH  = 16,
   parameter int WGT_WIDTH  = 16,
   parameter int BIAS_WIDTH = 32,
   parameter int ACC_WIDTH  = 48
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [BIAS_WIDTH-1:0] load_val,
   input  logic                  acc_en,
   input  logic [ACT_WIDTH-1:0]  act,
   input  logic [WGT_WIDTH-1:0]  wgt,
   output logic [ACC_WIDTH-1:0]  acc
);

   logic [ACC_WIDTH-1:0] act_x;
   logic [ACC_WIDTH-1:0] wgt_x;
   logic [ACC_WIDTH-1:0] prod;
   logic [ACC_WIDTH-1:0] term;
   logic [ACC_WIDTH-1:0] bias_x;

   assign act_x  = ACC_WIDTH'($signed(act));
   assign wgt_x  = ACC_WIDTH'($signed(wgt));
   assign bias_x = ACC_WIDTH'($signed(load_val));
   assign prod   = act_x * wgt_x;
   assign term   = prod * ACC_WIDTH'(ARRAY_N);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (load) begin
         acc <= bias_x;
      end else if (acc_en) begin
         acc <= acc + term;
      end
   end

endmodule

// File: rtl/systolic_array_bist_driver.sv
// Tile-by-tile stimulus generator and lane checker for systolic_array.
// Clears, loads bias, streams K_STEPS vectors, then checks the output write.
module systolic_array_bist_driver
   import sa_bist_pkg::*;
#(
   parameter int ARRAY_N         = 4,
   parameter int ARRAY_M         = 4,
   parameter int ACT_WIDTH       = 16,
   parameter int WGT_WIDTH       = 16,
   parameter int BIAS_WIDTH      = 32,
   parameter int ACC_WIDTH       = 48,
   parameter int OBUF_ADDR_WIDTH = 16,
   parameter int BBUF_ADDR_WIDTH = 16,
   parameter int K_STEPS         = 8,
   parameter int NUM_TILES       = 4,
   parameter int TIMEOUT         = 256
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic [1:0]                           mode,
   input  logic [ACT_WIDTH-1:0]                 act_seed,
   input  logic [WGT_WIDTH-1:0]                 wgt_seed,
   input  logic [BIAS_WIDTH-1:0]                bias_seed,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 pass,
   output logic [15:0]                          err_count,
   output logic [15:0]                          first_err_tile,
   output logic [((ARRAY_M > 1) ? $clog2(ARRAY_M) : 1)-1:0] first_err_lane,
   output logic                                 timeout_err,
   output logic                                 sa_acc_clear,
   output logic [ARRAY_N*ACT_WIDTH-1:0]         sa_ibuf_read_data,
   output logic [ARRAY_N*ARRAY_M*WGT_WIDTH-1:0] sa_wbuf_read_data,
   output logic [ARRAY_M*BIAS_WIDTH-1:0]        sa_bbuf_read_data,
   output logic                                 sa_bias_read_req,
   output logic [BBUF_ADDR_WIDTH-1:0]           sa_bias_read_addr,
   output logic                                 sa_bias_prev_sw,
   output logic                                 sa_obuf_write_req,
   output logic [OBUF_ADDR_WIDTH-1:0]           sa_obuf_read_addr,
   output logic [ARRAY_M*ACC_WIDTH-1:0]         sa_obuf_read_data,
   input  logic [ARRAY_M*ACC_WIDTH-1:0]         sa_obuf_write_data,
   input  logic                                 sa_sys_obuf_write_req,
   input  logic [OBUF_ADDR_WIDTH-1:0]           sa_sys_obuf_write_addr
);

   localparam int KW = (K_STEPS > 1) ? $clog2(K_STEPS) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int LW = (ARRAY_M > 1) ? $clog2(ARRAY_M) : 1;

   state_t                state;
   state_t                nxt;
   logic [15:0]           tile;
   logic [KW-1:0]         k;
   logic [TW-1:0]         tmr;
   logic [ACC_WIDTH-1:0]  exp_acc;
   logic [ACT_WIDTH-1:0]  act_k;
   logic [WGT_WIDTH-1:0]  wgt_k;
   logic [BIAS_WIDTH-1:0] bias_t;
   logic                  last_step;
   logic                  last_tile;
   logic                  wr_wait;
   logic                  to_hit;
   logic                  start_ok;
   logic [15:0]           n_mis;
   logic [LW-1:0]         low_lane;
   logic [15:0]           err_inc;
   logic [LW-1:0]         err_lane;
   logic [16:0]           err_sum;
   logic                  unused_addr;

   assign unused_addr = ^sa_sys_obuf_write_addr;

   assign bias_t = bias_seed + BIAS_WIDTH'(tile);
   assign act_k  = act_seed
                 + ((mode == MODE_RAMP_ACT) ? ACT_WIDTH'(k) : '0);
   assign wgt_k  = wgt_seed
                 + ((mode == MODE_RAMP_WGT) ? WGT_WIDTH'(k) : '0);

   assign last_step = (k == KW'(K_STEPS - 1));
   assign last_tile = (tile == 16'(NUM_TILES - 1));
   assign start_ok  = (state == S_IDLE) && start;
   assign wr_wait   = (state == S_WAIT) && sa_sys_obuf_write_req;
   assign to_hit    = (state == S_WAIT) && !sa_sys_obuf_write_req
                    && (tmr == TW'(TIMEOUT - 1));

   assign sa_bias_prev_sw   = 1'b0;
   assign sa_obuf_read_addr = '0;
   assign sa_obuf_read_data = '0;

   sa_bist_expected_acc #(
      .ARRAY_N    (ARRAY_N),
      .ACT_WIDTH  (ACT_WIDTH),
      .WGT_WIDTH  (WGT_WIDTH),
      .BIAS_WIDTH (BIAS_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_exp (
      .clk      (clk),
      .rst_n    (reset),
      .load     (state == S_CLEAR),
      .load_val (bias_t),
      .acc_en   (state == S_STREAM),
      .act      (act_k),
      .wgt      (wgt_k),
      .acc      (exp_acc)
   );

   always_comb begin
      nxt               = state;
      busy              = 1'b0;
      done              = 1'b0;
      sa_acc_clear      = 1'b0;
      sa_bias_read_req  = 1'b0;
      sa_bias_read_addr = '0;
      sa_bbuf_read_data = '0;
      sa_ibuf_read_data = '0;
      sa_wbuf_read_data = '0;
      sa_obuf_write_req = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) nxt = S_CLEAR;
         end
         S_CLEAR: begin
            busy         = 1'b1;
            sa_acc_clear = 1'b1;
            nxt          = S_BIAS;
         end
         S_BIAS: begin
            busy              = 1'b1;
            sa_bias_read_req  = 1'b1;
            sa_bias_read_addr = BBUF_ADDR_WIDTH'(tile);
            sa_bbuf_read_data = (ARRAY_M*BIAS_WIDTH)'(
               rep_lanes(REP_W'(bias_t), BIAS_WIDTH, ARRAY_M));
            nxt               = S_STREAM;
         end
         S_STREAM: begin
            busy              = 1'b1;
            sa_ibuf_read_data = (ARRAY_N*ACT_WIDTH)'(
               rep_lanes(REP_W'(act_k), ACT_WIDTH, ARRAY_N));
            sa_wbuf_read_data = (ARRAY_N*ARRAY_M*WGT_WIDTH)'(
               rep_lanes(REP_W'(wgt_k), WGT_WIDTH, ARRAY_N*ARRAY_M));
            if (last_step) begin
               sa_obuf_write_req = 1'b1;
               nxt               = S_WAIT;
            end
         end
         S_WAIT: begin
            busy = 1'b1;
            if (wr_wait || to_hit) nxt = last_tile ? S_DONE : S_CLEAR;
         end
         S_DONE: begin
            done = 1'b1;
            nxt  = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
   end

   // Lane mismatch count and lowest failing lane of the captured write.
   always_comb begin
      n_mis    = '0;
      low_lane = '0;
      for (int j = ARRAY_M - 1; j >= 0; j--) begin
         if (sa_obuf_write_data[j*ACC_WIDTH +: ACC_WIDTH] != exp_acc) begin
            n_mis    = n_mis + 16'd1;
            low_lane = LW'(j);
         end
      end
   end

   always_comb begin
      err_inc  = '0;
      err_lane = '0;
      if (wr_wait) begin
         err_inc  = n_mis;
         err_lane = low_lane;
      end else if (to_hit || sa_sys_obuf_write_req) begin
         err_inc = 16'd1;
      end
   end

   assign err_sum = {1'b0, err_count} + {1'b0, err_inc};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         tile  <= '0;
         k     <= '0;
         tmr   <= '0;
      end else begin
         state <= nxt;
         unique case (state)
            S_IDLE:   if (start) tile <= '0;
            S_CLEAR:  k <= '0;
            S_STREAM: begin
               k   <= k + KW'(1);
               tmr <= '0;
            end
            S_WAIT: begin
               if (wr_wait || to_hit) tile <= tile + 16'd1;
               else                   tmr  <= tmr + TW'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_count      <= '0;
         first_err_tile <= '0;
         first_err_lane <= '0;
         timeout_err    <= 1'b0;
         pass           <= 1'b0;
      end else if (start_ok) begin
         err_count      <= '0;
         first_err_tile <= '0;
         first_err_lane <= '0;
         timeout_err    <= 1'b0;
         pass           <= 1'b0;
      end else begin
         if (to_hit) timeout_err <= 1'b1;
         if (err_inc != '0) begin
            err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
            if (err_count == '0) begin
               first_err_tile <= tile;
               first_err_lane <= err_lane;
            end
         end
         if (state == S_DONE) pass <= (err_count == '0);
      end
   end

endmodule
